// File: rtl/relm_div_seq.sv
// Multi-cycle sequencer for the DIV/FDIV path of the shared FP/integer datapath.
// Optional feature: define RELM_DIV_ABORT_EN to add an 'abort' input that cancels an op in flight.
module relm_div_seq #(
    parameter int WD         = 32,
    parameter int WOP        = 5,
    parameter int WC         = 65,
    parameter int DIV_LOOPS  = 10,
    parameter int FDIV_LOOPS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_fdiv,
    input  logic [WD-1:0]    req_n,
    input  logic [WD-1:0]    req_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WD-1:0]    rsp_q,
    output logic [WD-1:0]    rsp_aux,
    output logic             rsp_dz,
    output logic [WOP-1:0]   dp_op,
    output logic             dp_opb,
    output logic [WD-1:0]    dp_x,
    output logic [WD-1:0]    dp_a,
    output logic [WD-1:0]    dp_xb,
    output logic [WC+WD-1:0] dp_cb,
`ifdef RELM_DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WD-1:0]    dp_a_out,
    input  logic [WC+WD-1:0] dp_cb_out
);

    localparam int MAX_LOOPS = (DIV_LOOPS > FDIV_LOOPS) ? DIV_LOOPS : FDIV_LOOPS;
    localparam int CW        = (MAX_LOOPS > 1) ? $clog2(MAX_LOOPS) : 1;

    // Loop ops flag themselves with the loop-select bit above the op field plus bit 0.
    localparam logic [WD-1:0] LOOP_X = (WD'(1) << (WOP + 1)) | WD'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        LOOP,
        DONE
    } state_t;

    state_t           state;
    logic             fdiv_r;
    logic [WD-1:0]    n_r;
    logic [WD-1:0]    d_r;
    logic [WD-1:0]    a_r;
    logic [WC+WD-1:0] cb_r;
    logic [WD-1:0]    hdr_r;
    logic [CW-1:0]    cnt;
    logic             rsp_valid_r;
    logic             rsp_dz_r;

    // Sequencer: divide-by-zero short-circuits straight to DONE without touching the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fdiv_r      <= 1'b0;
            n_r         <= '0;
            d_r         <= '0;
            a_r         <= '0;
            cb_r        <= '0;
            hdr_r       <= '0;
            cnt         <= '0;
            rsp_valid_r <= 1'b0;
            rsp_dz_r    <= 1'b0;
        end else
`ifdef RELM_DIV_ABORT_EN
        if (abort && (state != IDLE)) begin
            state       <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_dz_r    <= 1'b0;
        end else
`endif
        begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        fdiv_r <= req_fdiv;
                        n_r    <= req_n;
                        d_r    <= req_d;
                        if (!req_fdiv && (req_d == '0)) begin
                            a_r         <= '1;
                            cb_r        <= {{WC{1'b0}}, req_n};
                            rsp_dz_r    <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    a_r  <= dp_a_out;
                    cb_r <= dp_cb_out;
                    if (fdiv_r) begin
                        hdr_r <= dp_a_out;
                    end
                    cnt   <= fdiv_r ? CW'(FDIV_LOOPS - 1) : CW'(DIV_LOOPS - 1);
                    state <= LOOP;
                end
                LOOP: begin
                    a_r  <= dp_a_out;
                    cb_r <= dp_cb_out;
                    if (cnt == '0) begin
                        rsp_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_dz_r    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_dz    = rsp_dz_r;
    assign rsp_q     = a_r;
    assign rsp_aux   = fdiv_r ? hdr_r : cb_r[WD-1:0];

    // The datapath sees the divisor only during setup; afterwards it works from recirculated A/CB.
    assign dp_op  = {{(WOP-3){1'b0}}, (fdiv_r ? 3'b010 : 3'b011)};
    assign dp_opb = (state == LOOP);
    assign dp_x   = (state == LOOP) ? LOOP_X : '0;
    assign dp_a   = (state == SETUP) ? d_r : a_r;
    assign dp_xb  = n_r;
    assign dp_cb  = cb_r;

endmodule

// File: tb/tb_relm_div_seq.sv
// Self-checking bench for relm_div_seq with a behavioural restoring-division datapath model
// and a scoreboard of expected responses.
module tb_relm_div_seq;

    localparam int WD  = 32;
    localparam int WOP = 5;
    localparam int WC  = 65;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_fdiv;
    logic [WD-1:0]    req_n;
    logic [WD-1:0]    req_d;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WD-1:0]    rsp_q;
    logic [WD-1:0]    rsp_aux;
    logic             rsp_dz;
    logic [WOP-1:0]   dp_op;
    logic             dp_opb;
    logic [WD-1:0]    dp_x;
    logic [WD-1:0]    dp_a;
    logic [WD-1:0]    dp_xb;
    logic [WC+WD-1:0] dp_cb;
    logic [WD-1:0]    dp_a_out;
    logic [WC+WD-1:0] dp_cb_out;

    typedef struct {
        logic [31:0] q;
        logic [31:0] aux;
        logic        dz;
        int          lat;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;

    relm_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fdiv  (req_fdiv),
        .req_n     (req_n),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_aux   (rsp_aux),
        .rsp_dz    (rsp_dz),
        .dp_op     (dp_op),
        .dp_opb    (dp_opb),
        .dp_x      (dp_x),
        .dp_a      (dp_a),
        .dp_xb     (dp_xb),
        .dp_cb     (dp_cb),
        .dp_a_out  (dp_a_out),
        .dp_cb_out (dp_cb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model. CB layout: [31:0] partial remainder, [63:32] divisor,
    // [95:64] remaining dividend bits (DIV), [96] first-loop flag (FDIV).
    function automatic logic [128:0] dpStep(input logic [4:0] op, input logic opb,
                                            input logic [31:0] a, input logic [31:0] xb,
                                            input logic [96:0] cb);
        logic [32:0] r;
        logic [31:0] d;
        logic [31:0] nn;
        logic [31:0] q;
        logic [7:0]  e;
        logic [31:0] aOut;
        logic [96:0] cbOut;
        int          steps;
        r = '0; d = '0; nn = '0; q = '0; e = '0; aOut = '0; cbOut = '0; steps = 0;
        if (op[2:0] == 3'b011) begin
            if (!opb) begin
                d = a; nn = xb; r = '0; q = '0; steps = 2;
            end else begin
                d = cb[63:32]; nn = cb[95:64]; r = {1'b0, cb[31:0]}; q = a; steps = 3;
            end
            for (int i = 0; i < steps; i++) begin
                r  = {r[31:0], nn[31]};
                nn = {nn[30:0], 1'b0};
                if (r >= {1'b0, d}) begin
                    r = r - {1'b0, d};
                    q = {q[30:0], 1'b1};
                end else begin
                    q = {q[30:0], 1'b0};
                end
            end
            aOut  = q;
            cbOut = {1'b0, nn, d, r[31:0]};
        end else if (op[2:0] == 3'b010) begin
            if (!opb) begin
                e     = xb[30:23] - a[30:23] + 8'd127;
                aOut  = {xb[31] ^ a[31], e, 23'b0};
                cbOut = {1'b1, 32'b0, {8'b0, 1'b1, a[22:0]}, {8'b0, 1'b1, xb[22:0]}};
            end else begin
                d = cb[63:32];
                r = {1'b0, cb[31:0]};
                q = cb[96] ? 32'b0 : a;
                for (int i = 0; i < 3; i++) begin
                    if (r >= {1'b0, d}) begin
                        r = r - {1'b0, d};
                        q = {q[30:0], 1'b1};
                    end else begin
                        q = {q[30:0], 1'b0};
                    end
                    r = {r[31:0], 1'b0};
                end
                aOut  = q;
                cbOut = {1'b0, 32'b0, d, r[31:0]};
            end
        end
        return {aOut, cbOut};
    endfunction

    assign {dp_a_out, dp_cb_out} = dpStep(dp_op, dp_opb, dp_a, dp_xb, dp_cb);

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drives one request, waits for the response, compares against the scoreboard,
    // then holds rsp_ready low for holdCycles while poking junk requests.
    task automatic applyStimulus(input logic fdiv, input logic [31:0] n, input logic [31:0] d,
                                 input int holdCycles, input bit probeDp);
        expT         e;
        expT         got;
        int          edges;
        int          waitCnt;
        bit          sawLoop;
        logic [63:0] mn;
        logic [63:0] md;
        logic [7:0]  ex;
        if (!fdiv) begin
            if (d == 0) e = '{32'hFFFFFFFF, n, 1'b1, 1};
            else        e = '{n / d, n % d, 1'b0, 12};
        end else begin
            mn = {41'b0, 1'b1, n[22:0]};
            md = {41'b0, 1'b1, d[22:0]};
            ex = n[30:23] - d[30:23] + 8'd127;
            e  = '{32'((mn << 26) / md), {n[31] ^ d[31], ex, 23'b0}, 1'b0, 11};
        end
        sb.push_back(e);

        waitCnt = 0;
        while (!req_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_fdiv  = fdiv;
        req_n     = n;
        req_d     = d;
        @(posedge clk);
        edges   = 1;
        sawLoop = 0;
        @(negedge clk);
        req_valid = 1'b0;
        req_n     = $urandom;
        req_d     = $urandom;
        if (probeDp) begin
            checkOutput("setup_opb", dp_opb, 0);
            checkOutput("setup_x", dp_x, 0);
            checkOutput("setup_a", dp_a, d);
            checkOutput("setup_xb", dp_xb, n);
        end
        while (!rsp_valid && edges < 40) begin
            if (dp_opb) sawLoop = 1;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (probeDp && edges == 2) begin
                checkOutput("loop_opb", dp_opb, 1);
                checkOutput("loop_x", dp_x, 32'h41);
            end
        end

        checkOutput("rsp_valid", rsp_valid, 1);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            checkOutput("latency", edges, got.lat);
            checkOutput("rsp_q", rsp_q, got.q);
            checkOutput("rsp_aux", rsp_aux, got.aux);
            checkOutput("rsp_dz", rsp_dz, got.dz);
            checkOutput("used_loop", sawLoop, !got.dz);
            for (int i = 0; i < holdCycles; i++) begin
                req_valid = 1'b1;
                req_fdiv  = $urandom_range(0, 1);
                req_n     = $urandom;
                req_d     = $urandom;
                @(posedge clk);
                @(negedge clk);
                checkOutput("hold_valid", rsp_valid, 1);
                checkOutput("hold_q", rsp_q, got.q);
                checkOutput("hold_aux", rsp_aux, got.aux);
                checkOutput("hold_busy", req_ready, 0);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("exit_valid", rsp_valid, 0);
        checkOutput("exit_ready", req_ready, 1);
        checkOutput("exit_dz", rsp_dz, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rn;
        logic [31:0] rd;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_fdiv  = 1'b0;
        req_n     = '0;
        req_d     = '0;
        rsp_ready = 1'b0;
        #2;
        checkOutput("reset_valid", rsp_valid, 0);
        checkOutput("reset_ready", req_ready, 1);
        checkOutput("reset_dz", rsp_dz, 0);
        checkOutput("reset_q", rsp_q, 0);
        checkOutput("reset_cb", dp_cb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 32'd100, 32'd7, 0, 1'b1);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        applyStimulus(1'b0, 32'd5, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 32'h40C00000, 32'h40000000, 0, 1'b0);
        checkOutput("fdiv_hdr_exp", dut.rsp_aux[30:23], 8'h80);
        applyStimulus(1'b1, 32'hC0A00000, 32'h40400000, 0, 1'b0);
        applyStimulus(1'b0, 32'd1000, 32'd3, 5, 1'b0);
        applyStimulus(1'b0, 32'd9, 32'd0, 3, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rn = $urandom;
            rd = $urandom >> $urandom_range(0, 30);
            if (rd == 0) rd = 32'd3;
            applyStimulus(1'b0, rn, rd, 0, 1'b0);
        end

        // Reset in the middle of a loop: the op must vanish without a response.
        req_valid = 1'b1;
        req_fdiv  = 1'b0;
        req_n     = 32'd100;
        req_d     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_loop", dp_opb, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", rsp_valid, 0);
        checkOutput("midreset_ready", req_ready, 1);
        checkOutput("midreset_opb", dp_opb, 0);
        checkOutput("midreset_q", rsp_q, 0);
        checkOutput("midreset_aux", rsp_aux, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'd100, 32'd7, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
